// File: rtl/qam_pkg.sv
// Shared definitions for the 4-point QAM receive path: FSM states, carrier
// phase tables and the slicer's sign-to-bit mapping (common with the TX mapper).
package qam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SKIP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // A non-negative rail maps to 0 and a negative rail maps to 1.
    localparam logic BIT_POS = 1'b0;
    localparam logic BIT_NEG = 1'b1;

    // fs/4 carrier: cos = {+1,0,-1,0}, sin = {0,+1,0,-1}, indexed by phase.
    function automatic logic signed [1:0] cos_of(input logic [1:0] ph);
        case (ph)
            2'd0:    return 2'sb01;
            2'd2:    return 2'sb11;
            default: return 2'sb00;
        endcase
    endfunction

    function automatic logic signed [1:0] sin_of(input logic [1:0] ph);
        case (ph)
            2'd1:    return 2'sb01;
            2'd3:    return 2'sb11;
            default: return 2'sb00;
        endcase
    endfunction

endpackage

// File: rtl/qam_ps.sv
// 2-bit parallel-to-serial converter. A load emits b1 immediately and b0 on the
// following cycle, regardless of input sample timing.
module qam_ps (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [1:0] sym,
    output logic       bout,
    output logic       bout_valid
);

    logic b0_hold;
    logic pend;

    // Shift out b1 on load, then the held b0 one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            bout       <= 1'b0;
            bout_valid <= 1'b0;
            b0_hold    <= 1'b0;
            pend       <= 1'b0;
        end else if (load) begin
            bout       <= sym[1];
            bout_valid <= 1'b1;
            b0_hold    <= sym[0];
            pend       <= 1'b1;
        end else if (pend) begin
            bout       <= b0_hold;
            bout_valid <= 1'b1;
            pend       <= 1'b0;
        end else begin
            bout       <= 1'b0;
            bout_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/qam_rx_demod.sv
// 4-point QAM receive demodulator: fs/4 quadrature mix, integrate-and-dump per
// symbol, sign slicer, serial bit output and good-symbol lock detection.
// Pipeline: E0 registers the mixed sample, E1 dumps the symbol, E2 loads the
// serialiser and updates lock.
module qam_rx_demod
    import qam_pkg::*;
#(
    parameter int IF_W   = 18,
    parameter int OSR    = 8,
    parameter int SKIP   = 0,
    parameter int THRESH = 1024,
    parameter int LOCK_N = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   din_valid,
    input  logic signed [IF_W-1:0] IFin,
    output logic                   bout,
    output logic                   bout_valid,
    output logic                   sym_strobe,
    output logic                   lock
);

    localparam int ACC_W = IF_W + $clog2(OSR);
    localparam int CNT_W = $clog2(OSR);
    localparam int LCK_W = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OSR - 1);
    localparam logic signed [IF_W-1:0] MIN_V = {1'b1, {(IF_W-1){1'b0}}};
    localparam logic signed [IF_W-1:0] MAX_V = {1'b0, {(IF_W-1){1'b1}}};

    // Dropping en abandons everything in flight, exactly like a reset.
    logic clr;
    assign clr = reset | ~en;

    state_t      state;
    logic [1:0]  ph;
    logic [15:0] skip_cnt;
    logic        run_smp;

    assign run_smp = (state == ST_RUN) && din_valid;

    // Select/negate "multiplier"; the single unrepresentable negation saturates.
    function automatic logic signed [IF_W-1:0] mix_sel(input logic signed [IF_W-1:0] x,
                                                       input logic signed [1:0]      c);
        logic signed [IF_W-1:0] neg;
        neg = (x == MIN_V) ? MAX_V : -x;
        case (c)
            2'sb01:  return x;
            2'sb11:  return neg;
            default: return '0;
        endcase
    endfunction

    // Sequencing FSM and carrier phase; phase restarts whenever reception starts.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= ST_IDLE;
            ph       <= 2'd0;
            skip_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ph       <= 2'd0;
                    skip_cnt <= '0;
                    state    <= (SKIP == 0) ? ST_RUN : ST_SKIP;
                end
                ST_SKIP: if (din_valid) begin
                    ph       <= ph + 2'd1;
                    skip_cnt <= skip_cnt + 16'd1;
                    if (skip_cnt == 16'(SKIP - 1)) state <= ST_RUN;
                end
                ST_RUN: if (din_valid) ph <= ph + 2'd1;
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic                   mix_v;
    logic                   mix_last;
    logic signed [IF_W-1:0] mix_i;
    logic signed [IF_W-1:0] mix_q;
    logic [CNT_W-1:0]       cnt;

    // E0: mix the sample down and tag the last sample of each symbol.
    always_ff @(posedge clk) begin
        if (clr) begin
            mix_v    <= 1'b0;
            mix_last <= 1'b0;
            mix_i    <= '0;
            mix_q    <= '0;
            cnt      <= '0;
        end else begin
            mix_v <= run_smp;
            if (run_smp) begin
                mix_i    <= mix_sel(IFin, cos_of(ph));
                mix_q    <= mix_sel(IFin, -sin_of(ph));
                mix_last <= (cnt == LAST);
                cnt      <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    logic signed [ACC_W-1:0] acc_i, acc_q, dump_i, dump_q;
    logic signed [ACC_W-1:0] mix_i_x, mix_q_x;
    logic                    dump_v;

    assign mix_i_x = {{(ACC_W-IF_W){mix_i[IF_W-1]}}, mix_i};
    assign mix_q_x = {{(ACC_W-IF_W){mix_q[IF_W-1]}}, mix_q};

    // E1: integrate; the last sample goes straight into the dump while the
    // accumulator restarts, so no sample is lost between symbols.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc_i  <= '0;
            acc_q  <= '0;
            dump_i <= '0;
            dump_q <= '0;
            dump_v <= 1'b0;
        end else begin
            dump_v <= 1'b0;
            if (mix_v) begin
                if (mix_last) begin
                    dump_i <= acc_i + mix_i_x;
                    dump_q <= acc_q + mix_q_x;
                    acc_i  <= '0;
                    acc_q  <= '0;
                    dump_v <= 1'b1;
                end else begin
                    acc_i <= acc_i + mix_i_x;
                    acc_q <= acc_q + mix_q_x;
                end
            end
        end
    end

    assign sym_strobe = dump_v;

    logic [1:0]            sym;
    logic signed [ACC_W:0] ext_i, ext_q;
    logic [ACC_W:0]        abs_i, abs_q;
    logic                  good;
    logic [LCK_W-1:0]      good_cnt;

    assign sym[1] = dump_i[ACC_W-1] ? BIT_NEG : BIT_POS;
    assign sym[0] = dump_q[ACC_W-1] ? BIT_NEG : BIT_POS;
    assign ext_i  = {dump_i[ACC_W-1], dump_i};
    assign ext_q  = {dump_q[ACC_W-1], dump_q};
    assign abs_i  = ext_i[ACC_W] ? -ext_i : ext_i;
    assign abs_q  = ext_q[ACC_W] ? -ext_q : ext_q;
    assign good   = (abs_i >= (ACC_W+1)'(THRESH)) && (abs_q >= (ACC_W+1)'(THRESH));

    // E2: good-symbol run counter; a single weak symbol drops lock.
    always_ff @(posedge clk) begin
        if (clr) begin
            good_cnt <= '0;
            lock     <= 1'b0;
        end else if (dump_v) begin
            if (good) begin
                if (good_cnt != LCK_W'(LOCK_N)) good_cnt <= good_cnt + LCK_W'(1);
                lock <= (good_cnt >= LCK_W'(LOCK_N - 1));
            end else begin
                good_cnt <= '0;
                lock     <= 1'b0;
            end
        end
    end

    qam_ps u_ps (
        .clk        (clk),
        .reset      (clr),
        .load       (dump_v),
        .sym        (sym),
        .bout       (bout),
        .bout_valid (bout_valid)
    );

endmodule

// File: tb/tb_qam_rx_demod.sv
// Scoreboard bench for qam_rx_demod: the driver computes each symbol's expected
// bits/lock from the sample values with plain arithmetic and queues them; an
// independent monitor checks every serial bit the DUT emits.
module tb_qam_rx_demod;

    localparam int OSR    = 8;
    localparam int LOCK_N = 4;
    localparam int THRESH = 1024;
    localparam int MAXV   = 131071;
    localparam int MINV   = -131072;

    logic               clk = 1'b0;
    logic               reset, en, din_valid;
    logic signed [17:0] IFin;
    logic               bout, bout_valid, sym_strobe, lock;

    qam_rx_demod dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .din_valid  (din_valid),
        .IFin       (IFin),
        .bout       (bout),
        .bout_valid (bout_valid),
        .sym_strobe (sym_strobe),
        .lock       (lock)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b1;
        logic b0;
        logic lk;
        int   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   run_len = 0;
    int   smp[OSR];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int sat_neg(input int x);
        return (x == MINV) ? MAXV : -x;
    endfunction

    function automatic int clamp(input int x);
        if (x > MAXV) return MAXV;
        if (x < MINV) return MINV;
        return x;
    endfunction

    // Reference: correlate the symbol against the fs/4 carrier, slice the signs,
    // and track the good-symbol run for lock.
    task automatic push_exp(input int last_cyc);
        int   si, sq;
        bit   good;
        exp_t e;
        si = 0;
        sq = 0;
        for (int k = 0; k < OSR; k++) begin
            case (k % 4)
                0:       si += smp[k];
                1:       sq += sat_neg(smp[k]);
                2:       si += sat_neg(smp[k]);
                default: sq += smp[k];
            endcase
        end
        good    = (si >= THRESH || si <= -THRESH) && (sq >= THRESH || sq <= -THRESH);
        run_len = good ? ((run_len < LOCK_N) ? run_len + 1 : LOCK_N) : 0;
        e.b1    = (si < 0);
        e.b0    = (sq < 0);
        e.lk    = (run_len >= LOCK_N);
        e.cyc   = last_cyc;
        exp_q.push_back(e);
    endtask

    // Build a symbol waveform: rail signs from sym, amplitude amp, plus noise.
    task automatic fill_sym(input logic [1:0] sym, input int amp, input int noise, input bit sat);
        int si, sq, v;
        si = sym[1] ? -1 : 1;
        sq = sym[0] ? -1 : 1;
        for (int k = 0; k < OSR; k++) begin
            case (k % 4)
                0:       v = si * amp;
                1:       v = -sq * amp;
                2:       v = -si * amp;
                default: v = sq * amp;
            endcase
            if (noise > 0) v += int'($urandom_range(0, 2 * noise)) - noise;
            v = clamp(v);
            if (sat && $urandom_range(0, 15) == 0) v = MINV;
            smp[k] = v;
        end
    endtask

    // Drive n samples of smp[], with gap idle cycles before each; a full symbol
    // queues its expectation.
    task automatic send_symbol(input int gap, input int n);
        int last;
        last = 0;
        for (int k = 0; k < n; k++) begin
            repeat (gap) begin
                @(negedge clk);
                din_valid = 1'b0;
                IFin      = 18'($urandom);
            end
            @(negedge clk);
            din_valid = 1'b1;
            IFin      = 18'(smp[k]);
            last      = cyc;
        end
        if (n == OSR) push_exp(last);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid = 1'b0;
            IFin      = 18'($urandom);
        end
    endtask

    // Monitor: pop one expectation per serial symbol and check b1, b0, lock,
    // latency and the preceding strobe.
    exp_t cur;
    bit   in_b0       = 1'b0;
    logic prev_strobe = 1'b0;

    always @(negedge clk) begin
        if (in_b0) begin
            check("b0_valid", bout_valid, 1);
            check("b0", bout, cur.b0);
            in_b0 = 1'b0;
        end else if (bout_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_bit: got bout_valid=1 with bout=%0b, expected no output", bout);
            end else begin
                cur = exp_q.pop_front();
                check("b1", bout, cur.b1);
                check("lock", lock, cur.lk);
                check("latency", cyc - cur.cyc, 3);
                check("strobe_before_b1", prev_strobe, 1);
                in_b0 = 1'b1;
            end
        end
        prev_strobe = sym_strobe;
    end

    initial begin
        reset     = 1'b1;
        en        = 1'b1;
        din_valid = 1'b0;
        IFin      = '0;

        // Reset with en high and random input: all outputs stay low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            IFin      = 18'($urandom);
            din_valid = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst_bout", bout, 0);
            check("rst_bout_valid", bout_valid, 0);
            check("rst_sym_strobe", sym_strobe, 0);
            check("rst_lock", lock, 0);
        end
        @(negedge clk);
        reset     = 1'b0;
        din_valid = 1'b0;

        // Four clean symbols back-to-back: bits 00 01 10 11, lock after the 4th.
        for (int s = 0; s < 4; s++) begin
            fill_sym(2'(s), 1000, 0, 1'b0);
            send_symbol(0, OSR);
        end
        // All-zero symbol: slices to 00 and drops lock.
        for (int k = 0; k < OSR; k++) smp[k] = 0;
        send_symbol(0, OSR);

        // Same four symbols with din_valid every other cycle.
        for (int s = 0; s < 4; s++) begin
            fill_sym(2'(s), 1000, 0, 1'b0);
            send_symbol(1, OSR);
        end

        // Most-negative input on the Q rail must saturate, keeping q positive.
        smp = '{1000, MINV, -1000, 0, 1000, MINV, -1000, 0};
        send_symbol(0, OSR);
        idle(6);

        // Abort a symbol after 5 samples, then restart and send 11.
        fill_sym(2'b10, 1000, 0, 1'b0);
        send_symbol(0, 5);
        @(negedge clk);
        en        = 1'b0;
        din_valid = 1'b0;
        run_len   = 0;
        @(negedge clk);
        check("abort_lock", lock, 0);
        check("abort_bout_valid", bout_valid, 0);
        check("abort_strobe", sym_strobe, 0);
        idle(2);
        @(negedge clk);
        en        = 1'b1;
        din_valid = 1'b0;
        fill_sym(2'b11, 1000, 0, 1'b0);
        send_symbol(0, OSR);

        // Randomised symbols: mixed amplitudes, noise, gaps, saturating samples.
        for (int s = 0; s < 40; s++) begin
            int amp;
            amp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 300))
                                              : int'($urandom_range(200, 30000));
            fill_sym(2'($urandom), amp, int'($urandom_range(0, 400)), 1'b1);
            send_symbol(int'($urandom_range(0, 2)), OSR);
        end

        idle(1);
        for (int t = 0; t < 100 && (exp_q.size() != 0 || in_b0); t++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
